hamming_secded_codec: RTL and testbench
=======================================

# hamming_secded_codec

Parametrised, sequential SECDED Hamming codec. It encodes DATA_W-bit data words into extended Hamming codewords, or decodes codewords back into data with single-error correction and double-error detection. Mode is selected per transaction. Check bits are evaluated one per cycle by a small sequencer, so area stays constant as width grows. It sits between the datapath and memory/link interfaces behind valid/ready handshakes on both sides.

## Interface
- DATA_W, 11: data bits per word.
- P, 4: Hamming check bits. Legal only if 2^P >= DATA_W+P+1; otherwise elaboration fails.
- CW_W, DATA_W+P+1 (derived, not overridable): codeword width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- mode_i  in  1  0 = encode, 1 = decode; sampled at accept.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept.
- in_word  in  CW_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_data  out  DATA_W  encode: input data; decode: extracted (corrected when single) data.
- out_code  out  CW_W  encode: codeword; decode: corrected codeword (received word if double).
- err_single  out  1  decode: one error corrected.
- err_double  out  1  decode: uncorrectable error.
- err_pos  out  P  decode: corrected bit position when err_single, else 0.

## Operation
- Codeword layout: bit 0 = overall parity; positions 1..DATA_W+P are Hamming positions. Check bit k sits at position 2^k. Data bits fill the non-power-of-two positions in ascending order (d0 at 3, d1 at 5, ...).
- Check bit k = XOR of all positions 1..DATA_W+P whose index has bit k set, excluding position 2^k in encode. Overall = XOR of positions 1..DATA_W+P, plus bit 0 in decode.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch the word and mode, clear k, go to CALC.
  - CALC: each cycle compute check bit k (k=0..P-1) into the code register (encode) or the syndrome register (decode). At k=P compute overall parity, then go to FIX.
  - FIX: one cycle. Decode classification, with s = syndrome and o = overall mismatch:
    - s=0, o=0: clean.
    - o=1, s<=DATA_W+P: flip bit s (s=0 flips bit 0); err_single=1; err_pos=s.
    - o=0, s!=0: err_double=1; no correction.
    - o=1, s>DATA_W+P: err_double=1; no correction.
  - Encode: writes bit 0 and passes through. Then go to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready, go to IDLE.
- No accept in DONE, even when out_ready=1. Maximum throughput is one word per P+4 cycles.
- Reset values: in_ready=0 during reset (1 after release, state IDLE); out_valid=0; out_data=0; out_code=0; err_single=0; err_double=0; err_pos=0.
- Reset mid-operation: asynchronous return to IDLE; the in-flight word is discarded and no out_valid is produced.

## Timing
- Accept edge T (in_valid & in_ready). CALC runs T+1..T+P+1, FIX is T+P+2, and out_valid rises after edge T+P+2. For P=4, out_valid is high in the cycle following edge T+6.
- in_ready is low from the cycle after accept until the cycle after the out_valid & out_ready handshake.
- Outputs are registered, with no combinational path from in_* to out_*. Error flags are valid only while out_valid=1 and are 0 in encode mode.

## Structure
- Package ecc_pkg holds:
  - mode_e {ENC, DEC}
  - state_e {IDLE, CALC, FIX, DONE}
  - function data_pos(i) returning the Hamming position of data bit i
  - function is_pow2.
- Sub-module hamming_check_bit (combinational): inputs codeword, k, and an enc flag; output one parity bit. It is the only XOR tree, shared across all k.

## Test plan
- Encode, DATA_W=11/P=4: data 0x001 -> out_code 0x000F at T+6; data 0x7FF -> 0xFFFF; data 0x000 -> 0x0000; all flags 0.
- Decode single errors:
  - 0x004F (bit 6 flipped) -> err_single=1, err_pos=6, out_code 0x000F, out_data 0x001.
  - 0x000E -> err_single=1, err_pos=0, out_code 0x000F.
- Decode double error: 0x006F -> err_double=1, err_single=0, out_code 0x006F, out_data 0x007.
- DATA_W=8/P=4: codeword 13'h0112 (s=13, o=1) -> err_double=1, no correction. Also DATA_W=11/P=3 must fail elaboration.
- Backpressure: out_ready low for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; after out_ready, in_ready=1 exactly one cycle later.
- rst_n pulsed low during CALC -> all outputs 0 immediately; no out_valid after release; the next word encodes correctly.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types and position helpers for the SECDED codec
package ecc_pkg;

    typedef enum logic {ENC = 1'b0, DEC = 1'b1} mode_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Each power of two at or below the running position pushes data bit i one slot up.
    function automatic int data_pos(input int i);
        int pos;
        pos = i + 1;
        for (int k = 0; k < 30; k++) begin
            if ((1 << k) <= pos) pos++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_check_bit.sv
// rtl/hamming_check_bit.sv - single shared parity tree; k==P selects overall parity
module hamming_check_bit #(
    parameter int CW_W = 16,
    parameter int P    = 4,
    parameter int KW   = 3
) (
    input  logic [CW_W-1:0] code,
    input  logic [KW-1:0]   k,
    input  logic            enc,
    output logic            parity
);

    always_comb begin
        parity = 1'b0;
        for (int j = 1; j < CW_W; j++) begin
            if (int'(k) == P) begin
                parity = parity ^ code[j];
            end else if (((j >> k) & 1) == 1 && !(enc && j == (1 << k))) begin
                parity = parity ^ code[j];
            end
        end
        if (int'(k) == P && !enc) parity = parity ^ code[0];
    end

endmodule

// File: rtl/hamming_secded_codec.sv
// rtl/hamming_secded_codec.sv - sequential SECDED encoder/decoder, one check bit per cycle
module hamming_secded_codec
    import ecc_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int P      = 4,
    localparam int CW_W  = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW_W-1:0]   out_code,
    output logic              err_single,
    output logic              err_double,
    output logic [P-1:0]      err_pos
);

    localparam int N  = DATA_W + P;
    localparam int KW = $clog2(P + 1);

    if ((2 ** P) < CW_W) begin : g_bad_params
        $error("hamming_secded_codec: P too small for DATA_W");
    end

    state_e            state, state_nxt;
    mode_e             mode_q;
    logic [CW_W-1:0]   word_q;
    logic [KW-1:0]     k_q;
    logic [P-1:0]      syn_q;
    logic              ovr_q;
    logic              chk_bit;
    logic [CW_W-1:0]   enc_word;
    logic [CW_W-1:0]   fix_word;
    logic [DATA_W-1:0] fix_data;
    logic              fix_single;
    logic              fix_double;
    logic [P-1:0]      fix_pos;

    // Scatter data into non-power-of-two slots; check and overall slots start at zero.
    for (genvar i = 0; i < DATA_W; i++) begin : g_map
        localparam int POS = data_pos(i);
        assign enc_word[POS] = in_word[i];
        assign fix_data[i]   = fix_word[POS];
    end
    for (genvar c = 0; c < P; c++) begin : g_chk_slot
        assign enc_word[1 << c] = 1'b0;
    end
    assign enc_word[0] = 1'b0;

    hamming_check_bit #(.CW_W(CW_W), .P(P), .KW(KW)) u_check (
        .code   (word_q),
        .k      (k_q),
        .enc    (mode_q == ENC),
        .parity (chk_bit)
    );

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (int'(k_q) == P) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fix_word   = word_q;
        fix_single = 1'b0;
        fix_double = 1'b0;
        fix_pos    = '0;
        if (mode_q == ENC) begin
            fix_word[0] = ovr_q;
        end else if (ovr_q && int'(syn_q) <= N) begin
            fix_word   = word_q ^ (CW_W'(1) << syn_q);
            fix_single = 1'b1;
            fix_pos    = syn_q;
        end else if (ovr_q || syn_q != '0) begin
            fix_double = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= ENC;
            word_q     <= '0;
            k_q        <= '0;
            syn_q      <= '0;
            ovr_q      <= 1'b0;
            out_data   <= '0;
            out_code   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            err_pos    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mode_q <= mode_e'(mode_i);
                    word_q <= mode_i ? in_word : enc_word;
                    k_q    <= '0;
                    syn_q  <= '0;
                end
                CALC: begin
                    if (int'(k_q) == P) ovr_q <= chk_bit;
                    for (int c = 0; c < P; c++) begin
                        if (int'(k_q) == c) begin
                            if (mode_q == ENC) word_q[1 << c] <= chk_bit;
                            else               syn_q[c]       <= chk_bit;
                        end
                    end
                    k_q <= k_q + KW'(1);
                end
                FIX: begin
                    out_data   <= fix_data;
                    out_code   <= fix_word;
                    err_single <= fix_single;
                    err_double <= fix_double;
                    err_pos    <= fix_pos;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// tb/tb_hamming_secded_codec.sv - self-checking bench for hamming_secded_codec
module tb_hamming_secded_codec;

    typedef struct packed {
        logic [15:0] code;
        logic [10:0] data;
        logic        es;
        logic        ed;
        logic [3:0]  pos;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_data;
    logic [15:0] out_code;
    logic        err_single, err_double;
    logic [3:0]  err_pos;

    logic        b_mode = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_in_ready;
    logic [12:0] b_word = '0;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [12:0] b_out_code;
    logic        b_single, b_double;
    logic [3:0]  b_pos;

    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t cmp_e;
    res_t got;

    always #5 clk = ~clk;

    hamming_secded_codec #(.DATA_W(11), .P(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_code(out_code), .err_single(err_single), .err_double(err_double), .err_pos(err_pos)
    );

    hamming_secded_codec #(.DATA_W(8), .P(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode_i(b_mode), .in_valid(b_valid), .in_ready(b_in_ready),
        .in_word(b_word), .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
        .out_code(b_out_code), .err_single(b_single), .err_double(b_double), .err_pos(b_pos)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: place data, then each check bit makes its parity group even.
    function automatic logic [15:0] m_encode(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        int          di;
        c  = '0;
        di = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[di];
                di++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) if (((pos >> k) & 1) == 1) p = p ^ c[pos];
            c[1 << k] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] m_extract(input logic [15:0] c);
        logic [10:0] d;
        int          di;
        d  = '0;
        di = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[di] = c[pos];
                di++;
            end
        end
        return d;
    endfunction

    function automatic res_t m_enc_res(input logic [10:0] d);
        res_t r;
        r.code = m_encode(d);
        r.data = d;
        r.es   = 1'b0;
        r.ed   = 1'b0;
        r.pos  = '0;
        return r;
    endfunction

    // Syndrome as XOR of the indices of all set bits; overall as parity of the whole word.
    function automatic res_t m_decode(input logic [15:0] cw);
        res_t r;
        int   s;
        int   o;
        s = 0;
        o = 0;
        for (int pos = 0; pos < 16; pos++) begin
            if (cw[pos]) begin
                o = o ^ 1;
                s = s ^ pos;
            end
        end
        r.code = cw;
        r.es   = 1'b0;
        r.ed   = 1'b0;
        r.pos  = '0;
        if (o == 1 && s <= 15) begin
            r.code[s] = ~r.code[s];
            r.es      = 1'b1;
            r.pos     = 4'(s);
        end else if (o == 1 || s != 0) begin
            r.ed = 1'b1;
        end
        r.data = m_extract(r.code);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                cmp_e = exp_q[0];
                chk("cmp_code", out_code, cmp_e.code);
                chk("cmp_data", out_data, cmp_e.data);
                chk("cmp_single", err_single, cmp_e.es);
                chk("cmp_double", err_double, cmp_e.ed);
                chk("cmp_pos", err_pos, cmp_e.pos);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic m, input logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", in_ready, 1);
        mode_i   = m;
        in_word  = w;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(m ? m_decode(w) : m_enc_res(w[10:0]));
        #1;
        in_valid = 1'b0;
        in_word  = 16'($urandom);
        mode_i   = 1'($urandom);
    endtask

    task automatic wait_result(output res_t g, output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            chk("in_ready_busy", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        g = {out_code, out_data, err_single, err_double, err_pos};
    endtask

    task automatic run(input logic m, input logic [15:0] w, output res_t g);
        int l;
        send(m, w);
        wait_result(g, l);
        chk("latency", l, 6);
        @(negedge clk);
        chk("in_ready_after_hs", in_ready, 1);
    endtask

    task automatic directed(input string nm, input logic m, input logic [15:0] w,
                            input logic [15:0] ec, input logic [10:0] edat,
                            input logic es, input logic edb, input logic [3:0] ep);
        res_t g;
        run(m, w, g);
        chk({nm, "_code"}, g.code, ec);
        chk({nm, "_data"}, g.data, edat);
        chk({nm, "_single"}, g.es, es);
        chk({nm, "_double"}, g.ed, edb);
        chk({nm, "_pos"}, g.pos, ep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        r;
        logic [10:0] d;
        logic [15:0] cw;
        int          b1, b2, lat, n;
        logic        seen;

        chk("pin_enc_001", m_encode(11'h001), 16'h000F);
        chk("pin_enc_7ff", m_encode(11'h7FF), 16'hFFFF);
        r = m_decode(16'h004F);
        chk("pin_dec_4f", {r.code, 3'b0, r.es, r.ed, r.pos}, {16'h000F, 3'b0, 1'b1, 1'b0, 4'd6});
        r = m_decode(16'h006F);
        chk("pin_dec_6f", {r.code, 5'b0, r.data}, {16'h006F, 5'b0, 11'h007});

        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {out_code, out_data, err_single, err_double, err_pos}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        directed("enc_001", 1'b0, 16'h0001, 16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);
        directed("enc_7ff", 1'b0, 16'hF7FF, 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
        directed("enc_000", 1'b0, 16'h0000, 16'h0000, 11'h000, 1'b0, 1'b0, 4'd0);
        directed("dec_4f", 1'b1, 16'h004F, 16'h000F, 11'h001, 1'b1, 1'b0, 4'd6);
        directed("dec_0e", 1'b1, 16'h000E, 16'h000F, 11'h001, 1'b1, 1'b0, 4'd0);
        directed("dec_6f", 1'b1, 16'h006F, 16'h006F, 11'h007, 1'b0, 1'b1, 4'd0);
        directed("dec_clean", 1'b1, 16'hFFFF, 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < 6; i++) begin
            d  = 11'($urandom);
            cw = m_encode(d);
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            run(1'b0, {5'($urandom), d}, r);
            run(1'b1, cw ^ (16'd1 << b1), r);
            run(1'b1, cw ^ (16'd1 << b1) ^ (16'd1 << b2), r);
        end

        out_ready = 1'b0;
        send(1'b0, 16'h05A5);
        wait_result(got, lat);
        chk("bp_latency", lat, 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_pre_hs", in_ready, 0);
        @(negedge clk);
        chk("bp_in_ready_post_hs", in_ready, 1);
        chk("bp_out_valid_post_hs", out_valid, 0);

        send(1'b0, 16'h02C3);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_outputs", {out_code, out_data, err_single, err_double, err_pos}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("no_valid_after_rst", seen, 0);
        directed("enc_after_rst", 1'b0, 16'h0001, 16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);

        @(negedge clk);
        b_mode  = 1'b1;
        b_word  = 13'h0112;
        b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("w8_out_valid", b_out_valid, 1);
        chk("w8_double", b_double, 1);
        chk("w8_single", b_single, 0);
        chk("w8_code", b_out_code, 13'h0112);
        chk("w8_data", b_out_data, 8'h00);
        chk("w8_pos", b_pos, 4'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
